// File: rtl/rgmii_iddr_rx_pkg.sv
// rtl/rgmii_iddr_rx_pkg.sv - shared constants and types for the RGMII DDR receive front end
// Contents: preamble/SFD byte values, framing FSM state encoding, in-band speed codes.
package rgmii_iddr_rx_pkg;

   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_DATA = 2'd2,
      ST_DROP = 2'd3
   } rx_state_t;

   localparam logic [1:0] SPEED_10M  = 2'd0;
   localparam logic [1:0] SPEED_100M = 2'd1;
   localparam logic [1:0] SPEED_1G   = 2'd2;

endpackage

// File: rtl/rgmii_iddr_rx_iddr_lane.sv
// rtl/rgmii_iddr_rx_iddr_lane.sv - single-pin DDR input capture returning {fall, rise}
// Ports: i_clk sample clock, i_reset sync active-high, i_d DDR pin,
//        o_q {fall, rise} of the bit period that started one rising edge earlier.
// Macro IDDR_VENDOR_PRIM selects the vendor IDDR primitive; otherwise a behavioural model.
module iddr_lane (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_d,
   output logic [1:0] o_q
);

`ifdef IDDR_VENDOR_PRIM
   logic q_rise, q_fall;

   IDDR #(
      .DDR_CLK_EDGE ("SAME_EDGE_PIPELINED"),
      .SRTYPE       ("SYNC")
   ) u_iddr (
      .Q1 (q_rise),
      .Q2 (q_fall),
      .C  (i_clk),
      .CE (1'b1),
      .D  (i_d),
      .R  (i_reset),
      .S  (1'b0)
   );

   assign o_q = {q_fall, q_rise};
`else
   logic rise_p;
   logic fall_n;

   always_ff @(posedge i_clk) begin
      rise_p <= i_d;
   end

   always_ff @(negedge i_clk) begin
      fall_n <= i_d;
   end

   // Re-time both halves onto the rising edge so the pair leaves together.
   always_ff @(posedge i_clk) begin
      if (i_reset) o_q <= 2'b00;
      else         o_q <= {fall_n, rise_p};
   end
`endif

endmodule

// File: rtl/rgmii_iddr_rx.sv
// rtl/rgmii_iddr_rx.sv - RGMII DDR receive front end with optional preamble/SFD framing
// Ports: i_clk RX clock, i_reset sync active-high, i_rxd/i_rxctl DDR pins,
//        o_valid/o_data/o_sof/o_eof/o_err byte stream, o_link_up/o_speed/o_full_duplex status.
// Macro RGMII_INBAND_EN enables in-band link status decode; otherwise status is tied 0.
module rgmii_iddr_rx #(
   parameter int NLANES      = 4,
   parameter int DELAY       = 1,
   parameter int OPT_FRAMING = 1
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [NLANES-1:0]   i_rxd,
   input  logic                i_rxctl,
   output logic                o_valid,
   output logic [2*NLANES-1:0] o_data,
   output logic                o_sof,
   output logic                o_eof,
   output logic                o_err,
   output logic                o_link_up,
   output logic [1:0]          o_speed,
   output logic                o_full_duplex
);
   import rgmii_iddr_rx_pkg::*;

   localparam int W = 2 * NLANES;

   logic [NLANES:0] pins;
   logic [NLANES:0] rise_s;
   logic [NLANES:0] fall_s;

   assign pins = {i_rxctl, i_rxd};

   // Lanes 0..NLANES-1 are data; lane NLANES is the control pin.
   for (genvar g = 0; g <= NLANES; g++) begin : g_lane
      logic [1:0] q;
      iddr_lane u_iddr (
         .i_clk   (i_clk),
         .i_reset (i_reset),
         .i_d     (pins[g]),
         .o_q     (q)
      );
      assign rise_s[g] = q[0];
      assign fall_s[g] = q[1];
   end

   logic [W-1:0] cap_w;
   logic         cap_dv, cap_er;

   assign cap_w  = {fall_s[NLANES-1:0], rise_s[NLANES-1:0]};
   assign cap_dv = rise_s[NLANES];
   assign cap_er = rise_s[NLANES] ^ fall_s[NLANES];

   logic [W-1:0] p_w;
   logic         p_dv, p_er;

   if (DELAY == 0) begin : g_nodly
      assign p_w  = cap_w;
      assign p_dv = cap_dv;
      assign p_er = cap_er;
   end else begin : g_dly
      logic [W-1:0]     w_q [DELAY];
      logic [DELAY-1:0] dv_q, er_q;

      always_ff @(posedge i_clk) begin
         w_q[0] <= cap_w;
         for (int i = 1; i < DELAY; i++) w_q[i] <= w_q[i-1];
      end

      always_ff @(posedge i_clk) begin
         if (i_reset) begin
            dv_q <= '0;
            er_q <= '0;
         end else begin
            dv_q[0] <= cap_dv;
            er_q[0] <= cap_er;
            for (int i = 1; i < DELAY; i++) begin
               dv_q[i] <= dv_q[i-1];
               er_q[i] <= er_q[i-1];
            end
         end
      end

      assign p_w  = w_q[DELAY-1];
      assign p_dv = dv_q[DELAY-1];
      assign p_er = er_q[DELAY-1];
   end

   if (OPT_FRAMING != 0 && NLANES == 4) begin : g_frame
      // After reset the pipeline drains zeros for DELAY+1 cycles; only a dv
      // low seen after that proves we are between frames again.
      localparam logic [2:0] FILL_INIT = 3'(DELAY + 1);

      rx_state_t  state, state_n;
      logic       first, first_n;
      logic       hold;
      logic [2:0] fill;
      logic       valid_n, sof_n, err_n, eof_n;

      always_ff @(posedge i_clk) begin
         if (i_reset) begin
            state <= ST_IDLE;
            first <= 1'b0;
         end else begin
            state <= state_n;
            first <= first_n;
         end
      end

      always_ff @(posedge i_clk) begin
         if (i_reset) begin
            hold <= 1'b1;
            fill <= FILL_INIT;
         end else if (fill != 3'd0) begin
            fill <= fill - 3'd1;
         end else if (!p_dv) begin
            hold <= 1'b0;
         end
      end

      always_comb begin
         state_n = state;
         first_n = first;
         valid_n = 1'b0;
         sof_n   = 1'b0;
         err_n   = 1'b0;
         eof_n   = 1'b0;
         case (state)
            ST_IDLE: begin
               if (p_dv) begin
                  if (hold)                    state_n = ST_DROP;
                  else if (p_w == PREAMBLE_BYTE) state_n = ST_PRE;
                  else if (p_w == SFD_BYTE) begin
                     state_n = ST_DATA;
                     first_n = 1'b1;
                  end else                     state_n = ST_DROP;
               end
            end
            ST_PRE: begin
               if (!p_dv)                      state_n = ST_IDLE;
               else if (p_w == PREAMBLE_BYTE)  state_n = ST_PRE;
               else if (p_w == SFD_BYTE) begin
                  state_n = ST_DATA;
                  first_n = 1'b1;
               end else                        state_n = ST_DROP;
            end
            ST_DATA: begin
               if (p_dv) begin
                  valid_n = 1'b1;
                  sof_n   = first;
                  err_n   = p_er;
                  first_n = 1'b0;
               end else begin
                  eof_n   = 1'b1;
                  state_n = ST_IDLE;
               end
            end
            ST_DROP: begin
               if (!p_dv) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
         endcase
      end

      always_ff @(posedge i_clk) begin
         if (i_reset) begin
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_err   <= 1'b0;
            o_eof   <= 1'b0;
            o_data  <= '0;
         end else begin
            o_valid <= valid_n;
            o_sof   <= sof_n;
            o_err   <= err_n;
            o_eof   <= eof_n;
            o_data  <= p_w;
         end
      end
   end else begin : g_raw
      always_ff @(posedge i_clk) begin
         if (i_reset) begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            o_data  <= '0;
         end else begin
            o_valid <= p_dv;
            o_err   <= p_er;
            o_data  <= p_w;
         end
      end

      assign o_sof = 1'b0;
      assign o_eof = 1'b0;
   end

`ifdef RGMII_INBAND_EN
   if (NLANES == 4) begin : g_inband
      // Between frames the PHY repeats its status nibble on both edges.
      always_ff @(posedge i_clk) begin
         if (i_reset) begin
            o_link_up     <= 1'b0;
            o_speed       <= SPEED_10M;
            o_full_duplex <= 1'b0;
         end else if (!p_dv && !p_er && (p_w[3:0] == p_w[7:4])) begin
            o_link_up     <= p_w[0];
            o_speed       <= p_w[2:1];
            o_full_duplex <= p_w[3];
         end
      end
   end else begin : g_noinband
      assign o_link_up     = 1'b0;
      assign o_speed       = 2'd0;
      assign o_full_duplex = 1'b0;
   end
`else
   assign o_link_up     = 1'b0;
   assign o_speed       = 2'd0;
   assign o_full_duplex = 1'b0;
`endif

endmodule
